tlb_assoc_store: RTL and testbench

Parametrised set-associative TLB array, successor to the fixed 16-set/4-way storage block. It adds registered lookup with tag compare and hit/miss, true-LRU replacement with automatic victim selection on fill, single-entry invalidate, and a multi-cycle full-flush sweep. It sits between the TLB control FSM (lookup/fill/invalidate requests) and the page-walker fill path.

---
 rtl/tlb_assoc_store_if.sv | 45 ++++
 rtl/tlb_assoc_store.sv | 200 ++++++++++++++++++++
 tb/tb_tlb_assoc_store.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_assoc_store_if.sv
// Request/response bundle between the TLB control FSM / page walker and the
// associative store; master = requester side, slave = storage array.
interface tlb_assoc_store_if #(
   parameter int NUM_SETS  = 16,
   parameter int NUM_WAYS  = 4,
   parameter int VPN_BITS  = 20,
   parameter int PPN_BITS  = 20,
   parameter int PERM_BITS = 2
);
   localparam int SET_BITS = $clog2(NUM_SETS);
   localparam int WAY_BITS = $clog2(NUM_WAYS);

   logic                         lk_valid;
   logic [VPN_BITS-1:0]          lk_vpn;
   logic                         lk_resp_valid;
   logic                         lk_hit;
   logic [WAY_BITS-1:0]          lk_way;
   logic [PPN_BITS-1:0]          lk_ppn;
   logic [PERM_BITS-1:0]         lk_perms;
   logic                         fill_en;
   logic [VPN_BITS-1:0]          fill_vpn;
   logic [PPN_BITS-1:0]          fill_ppn;
   logic [PERM_BITS-1:0]         fill_perms;
   logic                         inv_en;
   logic [VPN_BITS-1:0]          inv_vpn;
   logic                         flush_req;
   logic                         busy;
   logic [SET_BITS-1:0]          dbg_set;
   logic [NUM_WAYS-1:0]          dbg_valid;
   logic [NUM_WAYS*WAY_BITS-1:0] dbg_age;

   modport master (
      output lk_valid, lk_vpn, fill_en, fill_vpn, fill_ppn, fill_perms,
             inv_en, inv_vpn, flush_req, dbg_set,
      input  lk_resp_valid, lk_hit, lk_way, lk_ppn, lk_perms, busy,
             dbg_valid, dbg_age
   );

   modport slave (
      input  lk_valid, lk_vpn, fill_en, fill_vpn, fill_ppn, fill_perms,
             inv_en, inv_vpn, flush_req, dbg_set,
      output lk_resp_valid, lk_hit, lk_way, lk_ppn, lk_perms, busy,
             dbg_valid, dbg_age
   );
endinterface

// File: rtl/tlb_assoc_store.sv
// Set-associative TLB storage: registered lookup, true-LRU fill victim
// selection, single-entry invalidate and a one-set-per-cycle flush sweep.
module tlb_assoc_store #(
   parameter int NUM_SETS  = 16,
   parameter int NUM_WAYS  = 4,
   parameter int VPN_BITS  = 20,
   parameter int PPN_BITS  = 20,
   parameter int PERM_BITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   tlb_assoc_store_if.slave bus
);
   localparam int SET_BITS = $clog2(NUM_SETS);
   localparam int WAY_BITS = $clog2(NUM_WAYS);
   localparam int AGE_W    = NUM_WAYS * WAY_BITS;

   typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_e;

   function automatic logic [AGE_W-1:0] age_init();
      logic [AGE_W-1:0] r;
      r = '0;
      for (int w = 0; w < NUM_WAYS; w++) r[w*WAY_BITS +: WAY_BITS] = WAY_BITS'(w);
      return r;
   endfunction

   // Touched way becomes MRU; only ways younger than it age, keeping a permutation.
   function automatic logic [AGE_W-1:0] lru_touch(input logic [AGE_W-1:0] ages,
                                                  input logic [WAY_BITS-1:0] way);
      logic [AGE_W-1:0]    r;
      logic [WAY_BITS-1:0] a;
      logic [WAY_BITS-1:0] cur;
      r = ages;
      a = ages[int'(way)*WAY_BITS +: WAY_BITS];
      for (int w = 0; w < NUM_WAYS; w++) begin
         cur = ages[w*WAY_BITS +: WAY_BITS];
         if (WAY_BITS'(w) == way) r[w*WAY_BITS +: WAY_BITS] = '0;
         else if (cur < a)        r[w*WAY_BITS +: WAY_BITS] = cur + WAY_BITS'(1);
         else                     r[w*WAY_BITS +: WAY_BITS] = cur;
      end
      return r;
   endfunction

   state_e                state_q, state_d;
   logic [SET_BITS-1:0]   cnt_q, cnt_d;
   logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
   logic [AGE_W-1:0]      age_q   [NUM_SETS];
   logic [AGE_W-1:0]      age_d   [NUM_SETS];
   logic [VPN_BITS-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
   logic [VPN_BITS-1:0]   tag_d   [NUM_SETS][NUM_WAYS];
   logic [PPN_BITS-1:0]   ppn_q   [NUM_SETS][NUM_WAYS];
   logic [PPN_BITS-1:0]   ppn_d   [NUM_SETS][NUM_WAYS];
   logic [PERM_BITS-1:0]  perm_q  [NUM_SETS][NUM_WAYS];
   logic [PERM_BITS-1:0]  perm_d  [NUM_SETS][NUM_WAYS];

   logic                  lk_resp_valid_q, lk_resp_valid_d;
   logic                  lk_hit_q, lk_hit_d;
   logic [WAY_BITS-1:0]   lk_way_q, lk_way_d;
   logic [PPN_BITS-1:0]   lk_ppn_q, lk_ppn_d;
   logic [PERM_BITS-1:0]  lk_perms_q, lk_perms_d;

   logic [SET_BITS-1:0]   lk_set_s, fill_set_s, inv_set_s, mod_set_s;
   logic [NUM_WAYS-1:0]   lk_match_s, fill_match_s, inv_match_s, fill_free_s, fill_old_s;
   logic [WAY_BITS-1:0]   lk_way_s, fill_hit_way_s, free_way_s, lru_way_s, victim_s;
   logic                  idle_s, lk_acc_s, flush_go_s, inv_go_s, fill_go_s, lk_touch_s;

   // Request decode, tag compare and victim selection against current state.
   always_comb begin
      idle_s     = (state_q == IDLE);
      lk_set_s   = bus.lk_vpn[SET_BITS-1:0];
      fill_set_s = bus.fill_vpn[SET_BITS-1:0];
      inv_set_s  = bus.inv_vpn[SET_BITS-1:0];
      for (int w = 0; w < NUM_WAYS; w++) begin
         lk_match_s[w]   = valid_q[lk_set_s][w] && (tag_q[lk_set_s][w] == bus.lk_vpn);
         fill_match_s[w] = valid_q[fill_set_s][w] && (tag_q[fill_set_s][w] == bus.fill_vpn);
         inv_match_s[w]  = valid_q[inv_set_s][w] && (tag_q[inv_set_s][w] == bus.inv_vpn);
         fill_free_s[w]  = !valid_q[fill_set_s][w];
         fill_old_s[w]   = (age_q[fill_set_s][w*WAY_BITS +: WAY_BITS] == WAY_BITS'(NUM_WAYS-1));
      end
      lk_way_s       = '0;
      fill_hit_way_s = '0;
      free_way_s     = '0;
      lru_way_s      = '0;
      for (int w = NUM_WAYS-1; w >= 0; w--) begin
         lk_way_s       = lk_match_s[w]   ? WAY_BITS'(w) : lk_way_s;
         fill_hit_way_s = fill_match_s[w] ? WAY_BITS'(w) : fill_hit_way_s;
         free_way_s     = fill_free_s[w]  ? WAY_BITS'(w) : free_way_s;
         lru_way_s      = fill_old_s[w]   ? WAY_BITS'(w) : lru_way_s;
      end
      victim_s   = (|fill_match_s) ? fill_hit_way_s : ((|fill_free_s) ? free_way_s : lru_way_s);
      lk_acc_s   = idle_s && bus.lk_valid;
      flush_go_s = idle_s && bus.flush_req;
      inv_go_s   = idle_s && !bus.flush_req && bus.inv_en;
      fill_go_s  = idle_s && !bus.flush_req && !bus.inv_en && bus.fill_en;
      mod_set_s  = inv_go_s ? inv_set_s : fill_set_s;
      // A modify op on the lookup's set wins; the lookup's LRU update is lost.
      lk_touch_s = lk_acc_s && (|lk_match_s) && !((inv_go_s || fill_go_s) && (mod_set_s == lk_set_s));
   end

   // Next-state: FSM, LRU/array updates and lookup response.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      age_d    = age_q;
      tag_d    = tag_q;
      ppn_d    = ppn_q;
      perm_d   = perm_q;

      lk_resp_valid_d = lk_acc_s;
      lk_hit_d        = lk_acc_s && (|lk_match_s);
      lk_way_d        = lk_hit_d ? lk_way_s : '0;
      lk_ppn_d        = lk_hit_d ? ppn_q[lk_set_s][lk_way_s] : '0;
      lk_perms_d      = lk_hit_d ? perm_q[lk_set_s][lk_way_s] : '0;

      age_d[lk_set_s] = lk_touch_s ? lru_touch(age_q[lk_set_s], lk_way_s) : age_q[lk_set_s];

      if (inv_go_s) begin
         valid_d[inv_set_s] = valid_q[inv_set_s] & ~inv_match_s;
      end else if (fill_go_s) begin
         valid_d[fill_set_s][victim_s] = 1'b1;
         tag_d[fill_set_s][victim_s]   = bus.fill_vpn;
         ppn_d[fill_set_s][victim_s]   = bus.fill_ppn;
         perm_d[fill_set_s][victim_s]  = bus.fill_perms;
         age_d[fill_set_s]             = lru_touch(age_q[fill_set_s], victim_s);
      end else begin
         valid_d[inv_set_s] = valid_d[inv_set_s];
      end

      case (state_q)
         IDLE: begin
            if (flush_go_s) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SWEEP: begin
            valid_d[cnt_q] = '0;
            age_d[cnt_q]   = age_init();
            if (cnt_q == SET_BITS'(NUM_SETS-1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + SET_BITS'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         lk_resp_valid_q <= 1'b0;
         lk_hit_q        <= 1'b0;
         lk_way_q        <= '0;
         lk_ppn_q        <= '0;
         lk_perms_q      <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            age_q[s]   <= age_init();
            for (int w = 0; w < NUM_WAYS; w++) begin
               tag_q[s][w]  <= '0;
               ppn_q[s][w]  <= '0;
               perm_q[s][w] <= '0;
            end
         end
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         lk_resp_valid_q <= lk_resp_valid_d;
         lk_hit_q        <= lk_hit_d;
         lk_way_q        <= lk_way_d;
         lk_ppn_q        <= lk_ppn_d;
         lk_perms_q      <= lk_perms_d;
         valid_q         <= valid_d;
         age_q           <= age_d;
         tag_q           <= tag_d;
         ppn_q           <= ppn_d;
         perm_q          <= perm_d;
      end
   end

   assign bus.lk_resp_valid = lk_resp_valid_q;
   assign bus.lk_hit        = lk_hit_q;
   assign bus.lk_way        = lk_way_q;
   assign bus.lk_ppn        = lk_ppn_q;
   assign bus.lk_perms      = lk_perms_q;
   assign bus.busy          = (state_q == SWEEP);
   assign bus.dbg_valid     = valid_q[bus.dbg_set];
   assign bus.dbg_age       = age_q[bus.dbg_set];
endmodule

// File: tb/tb_tlb_assoc_store.sv
// Self-checking bench for tlb_assoc_store: directed scenarios plus random
// traffic compared against an array-based reference of the TLB rules.
module tb_tlb_assoc_store;
   localparam int NS = 16;
   localparam int NW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   tlb_assoc_store_if #(.NUM_SETS(NS), .NUM_WAYS(NW)) bus ();
   tlb_assoc_store #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // reference contents
   bit m_valid [NS][NW];
   int m_tag   [NS][NW];
   int m_ppn   [NS][NW];
   int m_perm  [NS][NW];
   int m_age   [NS][NW];
   bit m_busy;
   int m_cnt;
   logic        e_rv, e_hit;
   logic [1:0]  e_way, e_perm;
   logic [19:0] e_ppn;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic m_clear_set(input int s);
      for (int w = 0; w < NW; w++) begin
         m_valid[s][w] = 1'b0;
         m_age[s][w]   = w;
      end
   endtask

   task automatic m_touch(input int s, input int w);
      int a;
      a = m_age[s][w];
      for (int i = 0; i < NW; i++)
         if (i == w) m_age[s][i] = 0;
         else if (m_age[s][i] < a) m_age[s][i] = m_age[s][i] + 1;
   endtask

   task automatic idle_in();
      bus.lk_valid = 1'b0; bus.fill_en = 1'b0; bus.inv_en = 1'b0; bus.flush_req = 1'b0;
   endtask

   // One clock: update reference from pre-edge inputs, advance, compare.
   task automatic step();
      int ls, hw, ms, v;
      bit iv, fi;
      logic [3:0] ev;
      logic [7:0] ea;
      e_rv = 0; e_hit = 0; e_way = 0; e_ppn = 0; e_perm = 0; hw = -1;
      ls = int'(bus.lk_vpn) % NS;
      if (!rst && !m_busy && bus.lk_valid) begin
         e_rv = 1;
         for (int w = 0; w < NW; w++)
            if (m_valid[ls][w] && m_tag[ls][w] == int'(bus.lk_vpn)) hw = w;
         if (hw >= 0) begin
            e_hit = 1; e_way = 2'(hw); e_ppn = 20'(m_ppn[ls][hw]); e_perm = 2'(m_perm[ls][hw]);
         end
      end
      if (rst) begin
         for (int s = 0; s < NS; s++) m_clear_set(s);
         m_busy = 0; m_cnt = 0;
      end else if (m_busy) begin
         m_clear_set(m_cnt);
         m_cnt++;
         if (m_cnt == NS) m_busy = 0;
      end else begin
         iv = !bus.flush_req && bus.inv_en;
         fi = !bus.flush_req && !bus.inv_en && bus.fill_en;
         ms = iv ? int'(bus.inv_vpn) % NS : int'(bus.fill_vpn) % NS;
         if (hw >= 0 && !((iv || fi) && ms == ls)) m_touch(ls, hw);
         if (bus.flush_req) begin
            m_busy = 1; m_cnt = 0;
         end else if (iv) begin
            for (int w = 0; w < NW; w++)
               if (m_valid[ms][w] && m_tag[ms][w] == int'(bus.inv_vpn)) m_valid[ms][w] = 0;
         end else if (fi) begin
            v = -1;
            for (int w = NW-1; w >= 0; w--)
               if (m_valid[ms][w] && m_tag[ms][w] == int'(bus.fill_vpn)) v = w;
            if (v < 0) for (int w = NW-1; w >= 0; w--) if (!m_valid[ms][w]) v = w;
            if (v < 0) for (int w = 0; w < NW; w++) if (m_age[ms][w] == NW-1) v = w;
            m_valid[ms][v] = 1;
            m_tag[ms][v]   = int'(bus.fill_vpn);
            m_ppn[ms][v]   = int'(bus.fill_ppn);
            m_perm[ms][v]  = int'(bus.fill_perms);
            m_touch(ms, v);
         end
      end
      @(posedge clk);
      #1;
      for (int w = 0; w < NW; w++) begin
         ev[w] = m_valid[bus.dbg_set][w];
         ea[w*2 +: 2] = 2'(m_age[bus.dbg_set][w]);
      end
      check_val("resp_valid", bus.lk_resp_valid, e_rv);
      check_val("hit", bus.lk_hit, e_hit);
      check_val("way", bus.lk_way, e_way);
      check_val("ppn", bus.lk_ppn, e_ppn);
      check_val("perms", bus.lk_perms, e_perm);
      check_val("busy", bus.busy, m_busy);
      check_val("dbg_valid", bus.dbg_valid, ev);
      check_val("dbg_age", bus.dbg_age, ea);
   endtask

   task automatic do_fill(input logic [19:0] vpn, input logic [19:0] ppn, input logic [1:0] pm);
      idle_in(); bus.fill_en = 1'b1; bus.fill_vpn = vpn; bus.fill_ppn = ppn; bus.fill_perms = pm;
      step();
   endtask

   task automatic do_lookup(input logic [19:0] vpn);
      idle_in(); bus.lk_valid = 1'b1; bus.lk_vpn = vpn;
      step();
   endtask

   function automatic logic [19:0] rnd_vpn();
      logic [19:0] v;
      v = 20'($urandom_range(0, 7) << 4);
      v[3:0] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      int cnt;
      idle_in();
      bus.lk_vpn = '0; bus.fill_vpn = '0; bus.fill_ppn = '0; bus.fill_perms = '0;
      bus.inv_vpn = '0; bus.dbg_set = '0;
      m_busy = 0; m_cnt = 0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      for (int s = 0; s < NS; s++) begin
         bus.dbg_set = 4'(s);
         #1;
         check_val("rst_dbg_valid", bus.dbg_valid, 4'h0);
         check_val("rst_dbg_age", bus.dbg_age, 8'hE4);
      end

      do_fill(20'h000A5, 20'h12345, 2'b11);
      do_lookup(20'h000A5);
      check_val("a5_hit", bus.lk_hit, 1'b1);
      check_val("a5_way", bus.lk_way, 2'd0);
      check_val("a5_ppn", bus.lk_ppn, 20'h12345);
      check_val("a5_perms", bus.lk_perms, 2'b11);
      do_lookup(20'h000B5);
      check_val("b5_miss", bus.lk_hit, 1'b0);
      check_val("b5_ppn", bus.lk_ppn, 20'h0);

      bus.dbg_set = 4'd3;
      do_fill(20'h00013, 20'h00001, 2'b01);
      do_fill(20'h00023, 20'h00002, 2'b01);
      do_fill(20'h00033, 20'h00003, 2'b01);
      do_fill(20'h00043, 20'h00004, 2'b01);
      do_lookup(20'h00013);
      do_fill(20'h00053, 20'h00005, 2'b10);
      do_lookup(20'h00053);
      check_val("lru_victim_way", bus.lk_way, 2'd1);
      do_lookup(20'h00023);
      check_val("evicted_miss", bus.lk_hit, 1'b0);
      do_lookup(20'h00013);
      check_val("mru_hit_way", bus.lk_way, 2'd0);
      do_fill(20'h00033, 20'hBBBBB, 2'b10);
      do_lookup(20'h00033);
      check_val("refill_way", bus.lk_way, 2'd2);
      check_val("refill_ppn", bus.lk_ppn, 20'hBBBBB);
      check_val("refill_valid", bus.dbg_valid, 4'hF);

      idle_in(); bus.inv_en = 1'b1; bus.inv_vpn = 20'h00013;
      bus.fill_en = 1'b1; bus.fill_vpn = 20'h00063; bus.fill_ppn = 20'h66666; bus.fill_perms = 2'b01;
      step();
      do_lookup(20'h00013);
      check_val("inv_miss", bus.lk_hit, 1'b0);
      do_lookup(20'h00063);
      check_val("dropped_fill_miss", bus.lk_hit, 1'b0);

      for (int s = 0; s < NS; s++) do_fill(20'h00100 | 20'(s), 20'(s * 3 + 1), 2'(s));
      idle_in(); bus.flush_req = 1'b1; bus.lk_valid = 1'b1; bus.lk_vpn = 20'h00105;
      step();
      check_val("preflush_hit", bus.lk_hit, 1'b1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.busy) break;
         cnt++;
         idle_in(); bus.lk_valid = 1'b1; bus.lk_vpn = 20'h00100 | 20'(i % NS);
         bus.flush_req = (i == 3);
         step();
      end
      check_val("flush_len", cnt, NS);
      for (int s = 0; s < NS; s++) begin
         bus.dbg_set = 4'(s);
         #1;
         check_val("flush_dbg_valid", bus.dbg_valid, 4'h0);
      end

      do_fill(20'h00077, 20'h77777, 2'b11);
      idle_in(); bus.flush_req = 1'b1;
      step();
      idle_in();
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("rst_mid_sweep_busy", bus.busy, 1'b0);

      for (int i = 0; i < 400; i++) begin
         idle_in();
         bus.lk_valid   = ($urandom_range(0, 99) < 60);
         bus.lk_vpn     = rnd_vpn();
         bus.fill_en    = ($urandom_range(0, 99) < 40);
         bus.fill_vpn   = ($urandom_range(0, 3) == 0) ? bus.lk_vpn : rnd_vpn();
         bus.fill_ppn   = 20'($urandom);
         bus.fill_perms = 2'($urandom_range(0, 3));
         bus.inv_en     = ($urandom_range(0, 99) < 12);
         bus.inv_vpn    = rnd_vpn();
         bus.flush_req  = ($urandom_range(0, 99) < 2);
         bus.dbg_set    = 4'($urandom_range(0, 15));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
